// File: rtl/wb_initiator.sv
// Wishbone single-transaction initiator. Accepts one command at a time,
// runs one bus cycle with an ack timeout, and returns the result over a valid/ready response port.
module wb_initiator #(
  parameter int ADDR_WIDTH     = 4,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_address,
  input  logic [DATA_WIDTH-1:0] cmd_writedata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_readdata,
  output logic                  rsp_error,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] wbm_address,
  output logic [DATA_WIDTH-1:0] wbm_writedata,
  input  logic [DATA_WIDTH-1:0] wbm_readdata,
  output logic                  wbm_write,
  output logic                  wbm_cycle,
  input  logic                  wbm_ack
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] CNT_MAX  = 16'hFFFF;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [15:0]             r_cnt;
  logic [15:0]             w_cnt_nxt;
  logic                    r_wbm_cycle;
  logic                    w_wbm_cycle_nxt;
  logic                    r_wbm_write;
  logic                    w_wbm_write_nxt;
  logic [ADDR_WIDTH-1:0]   r_wbm_address;
  logic [ADDR_WIDTH-1:0]   w_wbm_address_nxt;
  logic [DATA_WIDTH-1:0]   r_wbm_writedata;
  logic [DATA_WIDTH-1:0]   w_wbm_writedata_nxt;
  logic                    r_rsp_valid;
  logic                    w_rsp_valid_nxt;
  logic                    r_rsp_error;
  logic                    w_rsp_error_nxt;
  logic [DATA_WIDTH-1:0]   r_rsp_readdata;
  logic [DATA_WIDTH-1:0]   w_rsp_readdata_nxt;
  logic                    w_timeout;

  // The counter holds the number of ack-less BUS cycles already elapsed, so
  // the TIMEOUT_CYCLES-th such cycle is the one where it equals CNT_LAST.
  assign w_timeout = (r_cnt == CNT_LAST);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; ack takes priority over timeout
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_state_nxt = ST_BUS;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BUS: begin
        if (wbm_ack || w_timeout) begin
          w_state_nxt = ST_RESP;
        end else begin
          w_state_nxt = ST_BUS;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RESP;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Next values of the registered outputs and the timeout counter
  always_comb begin
    w_cnt_nxt           = r_cnt;
    w_wbm_cycle_nxt     = r_wbm_cycle;
    w_wbm_write_nxt     = r_wbm_write;
    w_wbm_address_nxt   = r_wbm_address;
    w_wbm_writedata_nxt = r_wbm_writedata;
    w_rsp_valid_nxt     = r_rsp_valid;
    w_rsp_error_nxt     = r_rsp_error;
    w_rsp_readdata_nxt  = r_rsp_readdata;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_cnt_nxt           = 16'd0;
          w_wbm_cycle_nxt     = 1'b1;
          w_wbm_write_nxt     = cmd_write;
          w_wbm_address_nxt   = cmd_address;
          w_wbm_writedata_nxt = cmd_writedata;
        end else begin
          w_wbm_cycle_nxt = 1'b0;
        end
      end
      ST_BUS: begin
        if (wbm_ack) begin
          w_wbm_cycle_nxt = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_error_nxt = 1'b0;
          if (r_wbm_write) begin
            w_rsp_readdata_nxt = {DATA_WIDTH{1'b0}};
          end else begin
            w_rsp_readdata_nxt = wbm_readdata;
          end
        end else if (w_timeout) begin
          w_wbm_cycle_nxt    = 1'b0;
          w_rsp_valid_nxt    = 1'b1;
          w_rsp_error_nxt    = 1'b1;
          w_rsp_readdata_nxt = {DATA_WIDTH{1'b0}};
        end else begin
          // Saturate rather than wrap so a stuck slave can never re-arm the timer
          if (r_cnt != CNT_MAX) begin
            w_cnt_nxt = r_cnt + 16'd1;
          end else begin
            w_cnt_nxt = r_cnt;
          end
        end
      end
      ST_RESP: begin
        w_wbm_cycle_nxt = 1'b0;
        if (rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
        end else begin
          w_rsp_valid_nxt = 1'b1;
        end
      end
      default: begin
        w_wbm_cycle_nxt = 1'b0;
        w_rsp_valid_nxt = 1'b0;
      end
    endcase
  end

  // Output and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt           <= 16'd0;
      r_wbm_cycle     <= 1'b0;
      r_wbm_write     <= 1'b0;
      r_wbm_address   <= {ADDR_WIDTH{1'b0}};
      r_wbm_writedata <= {DATA_WIDTH{1'b0}};
      r_rsp_valid     <= 1'b0;
      r_rsp_error     <= 1'b0;
      r_rsp_readdata  <= {DATA_WIDTH{1'b0}};
    end else begin
      r_cnt           <= w_cnt_nxt;
      r_wbm_cycle     <= w_wbm_cycle_nxt;
      r_wbm_write     <= w_wbm_write_nxt;
      r_wbm_address   <= w_wbm_address_nxt;
      r_wbm_writedata <= w_wbm_writedata_nxt;
      r_rsp_valid     <= w_rsp_valid_nxt;
      r_rsp_error     <= w_rsp_error_nxt;
      r_rsp_readdata  <= w_rsp_readdata_nxt;
    end
  end

  // cmd_ready is gated by reset so nothing is offered while reset is held
  assign cmd_ready     = (r_state == ST_IDLE) && !reset;
  assign busy          = (r_state != ST_IDLE);
  assign wbm_cycle     = r_wbm_cycle;
  assign wbm_write     = r_wbm_write;
  assign wbm_address   = r_wbm_address;
  assign wbm_writedata = r_wbm_writedata;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_error     = r_rsp_error;
  assign rsp_readdata  = r_rsp_readdata;

endmodule

// File: doc/wb_initiator.md
WB_INITIATOR -- requirements
Module: wb_initiator

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, Wishbone address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, Wishbone data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, max cycles in BUS without ack (legal range 1..65535).
REQ-004 SHALL have ports:
- clk  input  1  single clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- cmd_valid  input  1  command request
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready
- cmd_write  input  1  1 = write, 0 = read
- cmd_address  input  ADDR_WIDTH  target address
- cmd_writedata  input  DATA_WIDTH  write data
- rsp_valid  output  1  response available
- rsp_ready  input  1  response consumed when rsp_valid && rsp_ready
- rsp_readdata  output  DATA_WIDTH  read data (0 for writes and errors)
- rsp_error  output  1  1 = timeout, no ack
- busy  output  1  high in any state except IDLE
- wbm_address  output  ADDR_WIDTH  Wishbone address
- wbm_writedata  output  DATA_WIDTH  Wishbone write data
- wbm_readdata  input  DATA_WIDTH  Wishbone read data
- wbm_write  output  1  Wishbone write enable
- wbm_cycle  output  1  Wishbone bus cycle in progress
- wbm_ack  input  1  Wishbone acknowledge from slave

Function
REQ-005 SHALL implement FSM states IDLE, BUS, RESP; all outputs registered except cmd_ready and busy (decoded from state).
REQ-006 SHALL drive cmd_ready = 1 only in IDLE.
REQ-007 IDLE: on cmd_valid, latch cmd_write/cmd_address/cmd_writedata into wbm_write/wbm_address/wbm_writedata, set wbm_cycle = 1, clear timeout counter, go to BUS; wbm_cycle high starting the cycle after acceptance.
REQ-008 SHALL hold wbm_address, wbm_writedata, wbm_write stable for the whole time wbm_cycle = 1.
REQ-009 BUS: wbm_ack sampled every clock, including the first BUS cycle (combinational-ack slaves complete in 1 cycle).
REQ-010 BUS, wbm_ack = 1: clear wbm_cycle; capture wbm_readdata into rsp_readdata if read, else rsp_readdata = 0; rsp_error = 0; rsp_valid = 1; go to RESP.
REQ-011 BUS, wbm_ack = 0: increment counter; if counter reaches TIMEOUT_CYCLES-1 (i.e. TIMEOUT_CYCLES BUS cycles without ack): clear wbm_cycle, rsp_readdata = 0, rsp_error = 1, rsp_valid = 1, go to RESP.
REQ-012 Ack and timeout on same cycle: ack wins (normal completion, rsp_error = 0).
REQ-013 Counter SHALL be 16 bits, saturating; no wrap.
REQ-014 RESP: hold rsp_valid, rsp_readdata, rsp_error stable until rsp_ready = 1; on that edge clear rsp_valid, go to IDLE.
REQ-015 Next command accepted no earlier than the cycle after the response handshake (cmd_ready rises in IDLE); no back-to-back overlap, one outstanding transaction max.
REQ-016 wbm_ack SHALL be ignored in IDLE and RESP (late/spurious ack has no effect).
REQ-017 cmd_* inputs ignored outside IDLE; rsp_ready ignored outside RESP.
REQ-018 wbm_cycle SHALL never be high outside BUS.

Reset
REQ-019 reset high SHALL asynchronously force: state IDLE, wbm_cycle 0, wbm_write 0, wbm_address 0, wbm_writedata 0, rsp_valid 0, rsp_error 0, rsp_readdata 0, counter 0; busy 0, cmd_ready 0 while reset high.
REQ-020 reset mid-BUS SHALL drop wbm_cycle immediately (no clock needed), discard transaction, produce no response.
REQ-021 After reset release, cmd_ready = 1 on first clock edge in IDLE.

Verification
REQ-022 Write, combinational-ack slave: cmd write addr 0 data 0x000A -> wbm_cycle=1, wbm_write=1, wbm_address=0, wbm_writedata=0x000A for exactly 1 cycle; rsp_valid=1, rsp_error=0, rsp_readdata=0.
REQ-023 Read, slave acks after 3 cycles with wbm_readdata=0x1234 -> wbm_cycle high 4 cycles, rsp_readdata=0x1234, rsp_error=0.
REQ-024 Timeout, TIMEOUT_CYCLES=8, no ack -> wbm_cycle high exactly 8 cycles, rsp_valid=1, rsp_error=1, rsp_readdata=0; ack arriving 2 cycles later ignored.
REQ-025 Backpressure: rsp_ready held 0 for 5 cycles after read -> rsp_* stable, cmd_ready=0, second cmd_valid not accepted until cycle after rsp_ready=1.
REQ-026 Reset asserted asynchronously mid-BUS of read -> wbm_cycle=0 same instant, rsp_valid stays 0, next command after release completes normally.
REQ-027 Ack on same cycle as timeout (TIMEOUT_CYCLES=4, ack on 4th BUS cycle) -> rsp_error=0, rsp_readdata = wbm_readdata.
